// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline stall/flush controller: turns per-stage stall requests into a thermometer stall
// vector with bubble insertion, applies or defers flushes, and keeps stall statistics.
module pipeline_hazard_ctrl #(
  parameter int unsigned NUM_STAGES = 6,
  parameter int unsigned TIMEOUT    = 1024,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_STAGES-1:0] stall_req,
  input  logic [NUM_STAGES-1:0] flush_req,
  input  logic                  clr_stat,
  output logic [NUM_STAGES-1:0] stall,
  output logic [NUM_STAGES-1:0] bubble,
  output logic [NUM_STAGES-1:0] flush,
  output logic                  flush_pend,
  output logic                  stall_timeout,
  output logic [CNT_W-1:0]      stall_cycles
);

  localparam int unsigned IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);

  logic                  r_pend_vld;
  logic [IDX_W-1:0]      r_pend_idx;
  logic [WD_W-1:0]       r_wd_cnt;
  logic                  r_stall_timeout;
  logic [CNT_W-1:0]      r_stall_cycles;

  logic [IDX_W-1:0]      w_fk;
  logic                  w_f_any;
  logic                  w_f_vld;
  logic [IDX_W-1:0]      w_f_idx;
  logic                  w_blocked;
  logic                  w_apply;
  logic [NUM_STAGES-1:0] w_req_eff;
  logic [IDX_W-1:0]      w_h;
  logic                  w_r_any;

  always_comb begin
    w_fk    = '0;
    w_f_any = 1'b0;
    // Bit 0 (PC) never redirects, so it is excluded from the flush scan.
    for (int unsigned k = 0; k < NUM_STAGES; k++) begin
      if (flush_req[k] && (k != 0)) begin
        w_fk    = IDX_W'(k);
        w_f_any = 1'b1;
      end
    end
    w_f_vld = w_f_any | r_pend_vld;
    w_f_idx = w_fk;
    if (r_pend_vld && (r_pend_idx > w_fk)) w_f_idx = r_pend_idx;

    w_blocked = 1'b0;
    for (int unsigned k = 0; k < NUM_STAGES; k++) begin
      if (stall_req[k] && (k >= 32'(w_f_idx))) w_blocked = 1'b1;
    end
    w_apply = w_f_vld & ~w_blocked;

    w_req_eff = stall_req;
    if (w_apply) begin
      for (int unsigned k = 0; k < NUM_STAGES; k++) begin
        if (k < 32'(w_f_idx)) w_req_eff[k] = 1'b0;
      end
    end

    w_h     = '0;
    w_r_any = 1'b0;
    for (int unsigned k = 0; k < NUM_STAGES; k++) begin
      if (w_req_eff[k]) begin
        w_h     = IDX_W'(k);
        w_r_any = 1'b1;
      end
    end

    stall  = '0;
    bubble = '0;
    flush  = '0;
    if (rst) begin
      for (int unsigned j = 0; j < NUM_STAGES; j++) begin
        if (w_r_any && (j <= 32'(w_h)))     stall[j]  = 1'b1;
        if (w_r_any && (j == 32'(w_h) + 1)) bubble[j] = 1'b1;
        if (w_apply && (j >= 1) && (j < 32'(w_f_idx))) flush[j] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pend_vld      <= 1'b0;
      r_pend_idx      <= '0;
      r_wd_cnt        <= '0;
      r_stall_timeout <= 1'b0;
      r_stall_cycles  <= '0;
    end else begin
      // Blocked flushes merge into the pending slot; the older index always wins.
      if (w_f_vld) begin
        if (w_apply) begin
          r_pend_vld <= 1'b0;
          r_pend_idx <= '0;
        end else begin
          r_pend_vld <= 1'b1;
          r_pend_idx <= w_f_idx;
        end
      end

      if (stall[0]) begin
        if (r_wd_cnt < WD_W'(TIMEOUT)) r_wd_cnt <= r_wd_cnt + WD_W'(1);
      end else begin
        r_wd_cnt <= '0;
      end

      if (clr_stat) begin
        r_stall_cycles  <= '0;
        r_stall_timeout <= 1'b0;
      end else begin
        if (stall[0] && (r_stall_cycles != '1)) r_stall_cycles <= r_stall_cycles + CNT_W'(1);
        if (stall[0] && (r_wd_cnt >= WD_W'(TIMEOUT - 1))) r_stall_timeout <= 1'b1;
      end
    end
  end

  assign flush_pend    = r_pend_vld;
  assign stall_timeout = r_stall_timeout;
  assign stall_cycles  = r_stall_cycles;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (6 stages, TIMEOUT=8), plus a 3-bit counter
// instance sharing the same stimulus to observe statistics saturation.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] stall_req;
  logic [5:0] flush_req;
  logic       clr_stat;
  logic [5:0] stall, bubble, flush;
  logic       flush_pend, stall_timeout;
  logic [31:0] stall_cycles;
  logic [5:0] s_stall, s_bubble, s_flush;
  logic       s_flush_pend, s_stall_timeout;
  logic [2:0] s_stall_cycles;

  int unsigned checks = 0;
  int unsigned errors = 0;

  pipeline_hazard_ctrl #(.NUM_STAGES(6), .TIMEOUT(8), .CNT_W(32)) u_dut (
    .clk(clk), .rst(rst), .stall_req(stall_req), .flush_req(flush_req), .clr_stat(clr_stat),
    .stall(stall), .bubble(bubble), .flush(flush), .flush_pend(flush_pend),
    .stall_timeout(stall_timeout), .stall_cycles(stall_cycles)
  );

  pipeline_hazard_ctrl #(.NUM_STAGES(6), .TIMEOUT(8), .CNT_W(3)) u_sat (
    .clk(clk), .rst(rst), .stall_req(stall_req), .flush_req(flush_req), .clr_stat(clr_stat),
    .stall(s_stall), .bubble(s_bubble), .flush(s_flush), .flush_pend(s_flush_pend),
    .stall_timeout(s_stall_timeout), .stall_cycles(s_stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after a posedge; checks happen 2 units later.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #2;
  endtask

  initial begin
    rst = 1'b0; stall_req = '0; flush_req = '0; clr_stat = 1'b0;
    tick; tick;
    stall_req = 6'b010000; flush_req = 6'b001000; settle;
    chk("rst_stall",  32'(stall),  32'h0);
    chk("rst_bubble", 32'(bubble), 32'h0);
    chk("rst_flush",  32'(flush),  32'h0);
    chk("rst_pend",   32'(flush_pend), 32'h0);
    chk("rst_tmo",    32'(stall_timeout), 32'h0);
    chk("rst_cycles", stall_cycles, 32'h0);
    tick;
    stall_req = '0; flush_req = '0; rst = 1'b1;
    tick;

    stall_req = 6'b010000; settle;
    chk("t1_stall",  32'(stall),  32'b011111);
    chk("t1_bubble", 32'(bubble), 32'b100000);
    chk("t1_flush",  32'(flush),  32'h0);
    tick;
    stall_req = 6'b001100; settle;
    chk("t2_stall",  32'(stall),  32'b001111);
    chk("t2_bubble", 32'(bubble), 32'b010000);
    tick;
    stall_req = 6'b100000; settle;
    chk("wb_stall",  32'(stall),  32'b111111);
    chk("wb_bubble", 32'(bubble), 32'h0);
    tick;

    stall_req = 6'b000010; flush_req = 6'b001000; settle;
    chk("t3_flush",  32'(flush),  32'b000110);
    chk("t3_stall",  32'(stall),  32'h0);
    chk("t3_bubble", 32'(bubble), 32'h0);
    tick;
    stall_req = '0; flush_req = '0; settle;
    chk("t3_pend", 32'(flush_pend), 32'h0);
    chk("t3_idle", 32'(flush), 32'h0);
    tick;

    // Stall at the flush index itself blocks the flush.
    stall_req = 6'b001000; flush_req = 6'b001000; settle;
    chk("eq_flush",  32'(flush),  32'h0);
    chk("eq_stall",  32'(stall),  32'b001111);
    chk("eq_bubble", 32'(bubble), 32'b010000);
    tick;
    stall_req = '0; flush_req = '0; settle;
    chk("eq_pend",   32'(flush_pend), 32'h1);
    chk("eq_apply",  32'(flush), 32'b000110);
    tick;
    chk("eq_clear",  32'(flush_pend), 32'h0);

    stall_req = 6'b010000; flush_req = 6'b001000; settle;
    chk("t4c0_flush", 32'(flush), 32'h0);
    chk("t4c0_stall", 32'(stall), 32'b011111);
    tick;
    flush_req = 6'b000100; settle;
    chk("t4c1_pend",  32'(flush_pend), 32'h1);
    chk("t4c1_flush", 32'(flush), 32'h0);
    tick;
    flush_req = '0; settle;
    chk("t4c2_pend",  32'(flush_pend), 32'h1);
    chk("t4c2_flush", 32'(flush), 32'h0);
    tick;
    stall_req = '0; settle;
    chk("t4c3_flush", 32'(flush), 32'b000110);
    chk("t4c3_stall", 32'(stall), 32'h0);
    tick;
    chk("t4c4_pend",  32'(flush_pend), 32'h0);
    chk("t4c4_flush", 32'(flush), 32'h0);

    clr_stat = 1'b1;
    tick;
    clr_stat = 1'b0; settle;
    chk("t5_clr_cycles", stall_cycles, 32'h0);
    chk("t5_clr_tmo",    32'(stall_timeout), 32'h0);
    stall_req = 6'b000010;
    for (int i = 1; i <= 10; i++) begin
      tick;
      chk($sformatf("t5_tmo_%0d", i), 32'(stall_timeout), (i >= 8) ? 32'h1 : 32'h0);
    end
    stall_req = '0;
    tick;
    chk("t5_cycles",  stall_cycles, 32'd10);
    chk("t5_sat",     32'(s_stall_cycles), 32'd7);
    chk("t5_sticky",  32'(stall_timeout), 32'h1);
    clr_stat = 1'b1;
    tick;
    clr_stat = 1'b0; settle;
    chk("t5_clr2_cycles", stall_cycles, 32'h0);
    chk("t5_clr2_tmo",    32'(stall_timeout), 32'h0);
    chk("t5_clr2_sat",    32'(s_stall_cycles), 32'h0);

    stall_req = 6'b010000; flush_req = 6'b001000;
    tick;
    flush_req = '0; settle;
    chk("t6_pend_pre", 32'(flush_pend), 32'h1);
    rst = 1'b0; settle;
    chk("t6_rst_stall",  32'(stall),  32'h0);
    chk("t6_rst_bubble", 32'(bubble), 32'h0);
    chk("t6_rst_flush",  32'(flush),  32'h0);
    tick;
    chk("t6_pend_rst",   32'(flush_pend), 32'h0);
    chk("t6_cycles_rst", stall_cycles, 32'h0);
    rst = 1'b1; stall_req = '0; settle;
    chk("t6_flush_after", 32'(flush), 32'h0);
    chk("t6_stall_after", 32'(stall), 32'h0);
    tick;
    chk("t6_pend_after", 32'(flush_pend), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
